// File: rtl/spi_temp_reader.sv
// SPI mode-0 master that turns each timer tick edge into one sensor read.
// Optional command-byte prefix on MOSI is enabled with SPI_TEMP_CMD_EN.
module spi_temp_reader #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 16
`ifdef SPI_TEMP_CMD_EN
   ,
   parameter logic [7:0] CMD = 8'h00
`endif
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              tick_in,
   input  logic              miso_in,
   output logic              sclk_out,
   output logic              cs_n_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              busy_out,
   output logic              overrun_out
`ifdef SPI_TEMP_CMD_EN
   ,
   output logic              mosi_out
`endif
);

`ifdef SPI_TEMP_CMD_EN
   localparam int CMD_BITS = 8;
`else
   localparam int CMD_BITS = 0;
`endif
   localparam int TOTAL = DATA_W + CMD_BITS;
   localparam int BW    = $clog2(TOTAL);
   localparam int HW    = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(TOTAL - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state_q, state_d;
   logic              tick_q;
   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              req;
   logic              half_done;
`ifdef SPI_TEMP_CMD_EN
   logic [7:0]        cmd_q, cmd_d;
   logic              mosi_q, mosi_d;
`endif

   assign req       = tick_in ^ tick_q;
   assign half_done = (hcnt_q == H_LAST);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         tick_q  <= 1'b0;
         hcnt_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef SPI_TEMP_CMD_EN
         cmd_q   <= '0;
         mosi_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_in;
         hcnt_q  <= hcnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
`ifdef SPI_TEMP_CMD_EN
         cmd_q   <= cmd_d;
         mosi_q  <= mosi_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
`ifdef SPI_TEMP_CMD_EN
      cmd_d   = cmd_q;
      mosi_d  = mosi_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = SETUP;
               hcnt_d  = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
`ifdef SPI_TEMP_CMD_EN
               mosi_d  = CMD[7];
               cmd_d   = {CMD[6:0], 1'b0};
`endif
            end
         end
         SETUP: begin
            if (half_done) begin
               state_d = SHIFT;
               hcnt_d  = '0;
               sclk_d  = 1'b1;
               shreg_d = {shreg_q[DATA_W-2:0], miso_in};
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (!half_done) begin
               hcnt_d = hcnt_q + 1'b1;
            end else begin
               hcnt_d = '0;
               if (sclk_q) begin
                  // The last bit's low phase is served by HOLD.
                  sclk_d = 1'b0;
                  if (bit_q == B_LAST) begin
                     state_d = HOLD;
                  end
`ifdef SPI_TEMP_CMD_EN
                  mosi_d = cmd_q[7];
                  cmd_d  = {cmd_q[6:0], 1'b0};
`endif
               end else begin
                  sclk_d  = 1'b1;
                  bit_d   = bit_q + 1'b1;
                  shreg_d = {shreg_q[DATA_W-2:0], miso_in};
               end
            end
         end
         HOLD: begin
            if (half_done) begin
               state_d = IDLE;
               hcnt_d  = '0;
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               data_d  = shreg_q;
               valid_d = 1'b1;
`ifdef SPI_TEMP_CMD_EN
               mosi_d  = 1'b0;
`endif
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Overrun flags the request cycle itself, so it is decoded combinationally.
   assign overrun_out = busy_q & req;
   assign sclk_out    = sclk_q;
   assign cs_n_out    = cs_n_q;
   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign busy_out    = busy_q;
`ifdef SPI_TEMP_CMD_EN
   assign mosi_out    = mosi_q;
`endif

endmodule

// File: tb/tb_spi_temp_reader.sv
// Directed bench for spi_temp_reader with a mode-0 sensor model.
module tb_spi_temp_reader;
   localparam int CD = 2;
   localparam int DW = 16;
`ifdef SPI_TEMP_CMD_EN
   localparam int TOT = DW + 8;
`else
   localparam int TOT = DW;
`endif
   localparam int LAT = 1 + (2 * TOT + 1) * CD;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic tick_in = 1'b0;
   logic miso_in;
   logic sclk_out, cs_n_out, valid_out, busy_out, overrun_out;
   logic [DW-1:0] data_out;
`ifdef SPI_TEMP_CMD_EN
   logic mosi_out;
   logic [7:0] mosi_rec;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int edges = 0;
   int vcount = 0;
   logic [31:0] sens = '0;
   logic [31:0] load_word = '0;

   spi_temp_reader #(
      .CLK_DIV(CD),
      .DATA_W(DW)
`ifdef SPI_TEMP_CMD_EN
      ,
      .CMD(8'h50)
`endif
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .tick_in(tick_in),
      .miso_in(miso_in),
      .sclk_out(sclk_out),
      .cs_n_out(cs_n_out),
      .data_out(data_out),
      .valid_out(valid_out),
      .busy_out(busy_out),
      .overrun_out(overrun_out)
`ifdef SPI_TEMP_CMD_EN
      ,
      .mosi_out(mosi_out)
`endif
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;
   always @(posedge clk_in) if (valid_out === 1'b1) vcount <= vcount + 1;

   // Sensor: MSB presented when CS falls, advanced on each falling SCLK.
   assign miso_in = sens[TOT-1];
   always @(negedge cs_n_out) sens = load_word;
   always @(negedge sclk_out) if (cs_n_out === 1'b0) sens = sens << 1;

   always @(posedge sclk_out) begin
`ifdef SPI_TEMP_CMD_EN
      if (edges < 8) mosi_rec = {mosi_rec[6:0], mosi_out};
`endif
      edges = edges + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a read with a tick toggle and follows it to valid_out.
   // ovr_at > 0 injects a second tick edge in that cycle of the transaction.
   task automatic do_read(input string tag, input logic [15:0] w, input int ovr_at);
      int t0, k;
      load_word = {8'h00, 8'hE7, w};
      edges = 0;
      @(negedge clk_in);
      tick_in = ~tick_in;
      t0 = cyc;
      k = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_in);
         k = cyc - t0;
         if (k == 1) begin
            chk({tag, "_busy_T1"}, busy_out, 1);
            chk({tag, "_csn_T1"}, cs_n_out, 0);
         end
         if (k == LAT - 1) chk({tag, "_busy_end"}, busy_out, 1);
         if (ovr_at > 0 && k == ovr_at) begin
            tick_in = ~tick_in;
            #1 chk({tag, "_overrun_pulse"}, overrun_out, 1);
         end
         if (ovr_at > 0 && k == ovr_at + 1) chk({tag, "_overrun_clear"}, overrun_out, 0);
         if (valid_out === 1'b1) break;
      end
      chk({tag, "_latency"}, k, LAT);
      chk({tag, "_data"}, data_out, w);
      chk({tag, "_edges"}, edges, TOT);
      chk({tag, "_csn_done"}, cs_n_out, 1);
      chk({tag, "_busy_done"}, busy_out, 0);
`ifdef SPI_TEMP_CMD_EN
      chk({tag, "_mosi_cmd"}, mosi_rec, 8'h50);
`endif
      @(negedge clk_in);
      chk({tag, "_valid_one_cycle"}, valid_out, 0);
      chk({tag, "_data_hold"}, data_out, w);
   endtask

   initial begin
      int vc;
      // Reset state
      repeat (3) @(negedge clk_in);
      chk("rst_csn", cs_n_out, 1);
      chk("rst_sclk", sclk_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_overrun", overrun_out, 0);
      rst_in = 1'b0;

      // Idle with tick held low
      repeat (100) @(negedge clk_in);
      chk("idle_csn", cs_n_out, 1);
      chk("idle_sclk", sclk_out, 0);
      chk("idle_valid_count", vcount, 0);
      chk("idle_edges", edges, 0);

      // Rising then falling tick edge each start a read
      do_read("rise", 16'hA5C3, 0);
      repeat (5) @(negedge clk_in);
      do_read("fall", 16'h0001, 0);
      repeat (5) @(negedge clk_in);

      // Tick edge mid-transaction is dropped with an overrun pulse
      do_read("ovr", 16'hA5C3, 20);
      vc = vcount;
      repeat (80) @(negedge clk_in);
      chk("ovr_no_extra_valid", vcount, vc);
      chk("ovr_no_extra_edges", edges, TOT);
      chk("ovr_idle_csn", cs_n_out, 1);

      // Reset mid-read: outputs return to reset values at once
      load_word = {8'h00, 8'hE7, 16'h1234};
      @(negedge clk_in);
      tick_in = ~tick_in;
      repeat (30) @(negedge clk_in);
      chk("mid_busy_before_rst", busy_out, 1);
      vc = vcount;
      rst_in = 1'b1;
      tick_in = 1'b0;
      #1;
      chk("mid_rst_csn", cs_n_out, 1);
      chk("mid_rst_sclk", sclk_out, 0);
      chk("mid_rst_busy", busy_out, 0);
      chk("mid_rst_data", data_out, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (100) @(negedge clk_in);
      chk("mid_rst_no_valid", vcount, vc);
      chk("mid_rst_idle_csn", cs_n_out, 1);

      // Clean transaction after reset
      do_read("post_rst", 16'h3C5A, 0);
      repeat (2) @(negedge clk_in);
      do_read("back2back", 16'hFFFE, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
